// File: rtl/packet_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : packet_router_pkg
//  Description : Shared constants for the packet router CSR block: register
//                byte offsets, CTRL bit positions, AXI response codes and the
//                read/write channel state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package packet_router_pkg;

    // Register byte offsets (word aligned)
    localparam logic [31:0] REG_ID_OFFS      = 32'h0000_0000;
    localparam logic [31:0] REG_CTRL_OFFS    = 32'h0000_0004;
    localparam logic [31:0] REG_SCRATCH_OFFS = 32'h0000_0008;
    localparam logic [31:0] REG_DROP_OFFS    = 32'h0000_000C;
    localparam logic [31:0] REG_OUT_BASE     = 32'h0000_0010;

    // CTRL register bit positions
    localparam int CTRL_CLEAR_BIT = 0;
    localparam int CTRL_SNAP_BIT  = 1;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_HAVE_AW = 2'b01,
        WR_HAVE_W  = 2'b10,
        WR_RESP    = 2'b11
    } wr_state_t;

    // Only CTRL and SCRATCH accept writes; everything else answers SLVERR.
    function automatic logic wr_target_ok(input logic [31:0] addr);
        return (addr == REG_CTRL_OFFS) || (addr == REG_SCRATCH_OFFS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axil_wr_join.sv
`default_nettype none
// ============================================================================
//  Module      : axil_wr_join
//  Description : Accepts AXI-Lite AW and W beats independently (either order
//                or together), emits a single-cycle commit strobe with the
//                joined address/data/strobe, then holds the B response until
//                the master takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module axil_wr_join
    import packet_router_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_awaddr,
    input  logic        i_awvalid,
    output logic        o_awready,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_wstrb,
    input  logic        i_wvalid,
    output logic        o_wready,
    output logic [1:0]  o_bresp,
    output logic        o_bvalid,
    input  logic        i_bready,
    output logic        o_commit,
    output logic [31:0] o_commit_addr,
    output logic [31:0] o_commit_data,
    output logic [3:0]  o_commit_strb,
    input  logic [1:0]  i_commit_resp
);

    wr_state_t   r_state;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic [31:0] r_awaddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_aw_avail;
    logic w_w_avail;

    assign w_aw_hs    = i_awvalid & r_awready;
    assign w_w_hs     = i_wvalid  & r_wready;
    // A beat is available if it was captured earlier or is handshaking now
    assign w_aw_avail = (r_state == WR_HAVE_AW) | w_aw_hs;
    assign w_w_avail  = (r_state == WR_HAVE_W)  | w_w_hs;

    assign o_commit      = w_aw_avail & w_w_avail;
    assign o_commit_addr = (r_state == WR_HAVE_AW) ? r_awaddr : i_awaddr;
    assign o_commit_data = (r_state == WR_HAVE_W)  ? r_wdata  : i_wdata;
    assign o_commit_strb = (r_state == WR_HAVE_W)  ? r_wstrb  : i_wstrb;

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = r_bresp;

    // Write channel FSM: capture AW/W, commit when both present, hold B
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= WR_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_state)
                WR_IDLE, WR_HAVE_AW, WR_HAVE_W: begin
                    if (o_commit) begin
                        r_state   <= WR_RESP;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= i_commit_resp;
                    end else if (w_aw_hs) begin
                        r_awaddr  <= i_awaddr;
                        r_awready <= 1'b0;
                        r_state   <= WR_HAVE_AW;
                    end else if (w_w_hs) begin
                        r_wdata   <= i_wdata;
                        r_wstrb   <= i_wstrb;
                        r_wready  <= 1'b0;
                        r_state   <= WR_HAVE_W;
                    end
                end
                WR_RESP: begin
                    if (i_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_state   <= WR_IDLE;
                    end
                end
                default: r_state <= WR_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/packet_router_csr.sv
`default_nettype none
// ============================================================================
//  Module      : packet_router_csr
//  Description : AXI4-Lite control/status block for the N-output packet
//                router. ID / CTRL / SCRATCH / DROP / OUT_i register map,
//                SLVERR on unmapped or misaligned access, counter-clear pulse.
//                Optional feature macro PKT_ROUTER_CSR_SNAPSHOT_EN adds shadow
//                registers so counters can be frozen atomically via CTRL bit1.
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_router_csr
    import packet_router_pkg::*;
#(
    parameter int          NUM_OUTPUTS = 2,
    parameter int          ADDR_WIDTH  = 12,
    parameter logic [31:0] ID_VALUE    = 32'h5052_0002
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               s_axil_awaddr,
    input  logic                      s_axil_awvalid,
    output logic                      s_axil_awready,
    input  logic [31:0]               s_axil_wdata,
    input  logic [3:0]                s_axil_wstrb,
    input  logic                      s_axil_wvalid,
    output logic                      s_axil_wready,
    output logic [1:0]                s_axil_bresp,
    output logic                      s_axil_bvalid,
    input  logic                      s_axil_bready,
    input  logic [31:0]               s_axil_araddr,
    input  logic                      s_axil_arvalid,
    output logic                      s_axil_arready,
    output logic [31:0]               s_axil_rdata,
    output logic [1:0]                s_axil_rresp,
    output logic                      s_axil_rvalid,
    input  logic                      s_axil_rready,
    input  logic [32*NUM_OUTPUTS-1:0] pkt_count_out,
    input  logic [31:0]               pkt_count_drop,
    output logic                      clear_counters
);

    // Address bits above ADDR_WIDTH are ignored by masking them away
    localparam logic [31:0] c_addr_mask = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                        : ((32'd1 << ADDR_WIDTH) - 32'd1);

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    logic        w_commit;
    logic [31:0] w_commit_addr;
    logic [31:0] w_commit_data;
    logic [3:0]  w_commit_strb;
    logic [31:0] w_wr_addr;
    logic [1:0]  w_wr_resp;
    logic        w_ctrl_wr;

    assign w_wr_addr = w_commit_addr & c_addr_mask;
    assign w_wr_resp = wr_target_ok(w_wr_addr) ? RESP_OKAY : RESP_SLVERR;
    assign w_ctrl_wr = w_commit && (w_wr_addr == REG_CTRL_OFFS);

    axil_wr_join u_wr_join (
        .clk           (clk),
        .reset         (reset),
        .i_awaddr      (s_axil_awaddr),
        .i_awvalid     (s_axil_awvalid),
        .o_awready     (s_axil_awready),
        .i_wdata       (s_axil_wdata),
        .i_wstrb       (s_axil_wstrb),
        .i_wvalid      (s_axil_wvalid),
        .o_wready      (s_axil_wready),
        .o_bresp       (s_axil_bresp),
        .o_bvalid      (s_axil_bvalid),
        .i_bready      (s_axil_bready),
        .o_commit      (w_commit),
        .o_commit_addr (w_commit_addr),
        .o_commit_data (w_commit_data),
        .o_commit_strb (w_commit_strb),
        .i_commit_resp (w_wr_resp)
    );

    logic [31:0] r_scratch;
    logic        r_clear;

    // SCRATCH register, byte-enabled by wstrb
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scratch <= '0;
        end else if (w_commit && (w_wr_addr == REG_SCRATCH_OFFS)) begin
            for (int b = 0; b < 4; b++) begin
                if (w_commit_strb[b]) begin
                    r_scratch[8*b +: 8] <= w_commit_data[8*b +: 8];
                end
            end
        end
    end

    // Clear pulse appears the cycle after the CTRL write commits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clear <= 1'b0;
        end else begin
            r_clear <= w_ctrl_wr && w_commit_data[CTRL_CLEAR_BIT];
        end
    end

    assign clear_counters = r_clear;

    // ------------------------------------------------------------------
    // Counter sources seen by the read mux (live or snapshot)
    // ------------------------------------------------------------------
    logic [31:0] w_rd_out [NUM_OUTPUTS];
    logic [31:0] w_rd_drop;

`ifdef PKT_ROUTER_CSR_SNAPSHOT_EN
    logic        w_snap;
    logic [31:0] r_shadow_drop;

    // Snapshot happens on the commit edge, so it sees pre-clear values
    assign w_snap = w_ctrl_wr && w_commit_data[CTRL_SNAP_BIT];

    // Drop counter shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow_drop <= '0;
        end else if (w_snap) begin
            r_shadow_drop <= pkt_count_drop;
        end
    end

    assign w_rd_drop = r_shadow_drop;
`else
    assign w_rd_drop = pkt_count_drop;
`endif

    for (genvar gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
`ifdef PKT_ROUTER_CSR_SNAPSHOT_EN
        logic [31:0] r_shadow;

        // Per-output shadow register
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_shadow <= '0;
            end else if (w_snap) begin
                r_shadow <= pkt_count_out[32*gi +: 32];
            end
        end

        assign w_rd_out[gi] = r_shadow;
`else
        assign w_rd_out[gi] = pkt_count_out[32*gi +: 32];
`endif
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_addr;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;

    assign w_rd_addr = s_axil_araddr & c_addr_mask;

    // Address decode for reads; unmapped or misaligned returns SLVERR with 0
    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_SLVERR;
        if (w_rd_addr[1:0] == 2'b00) begin
            case (w_rd_addr)
                REG_ID_OFFS: begin
                    w_rd_data = ID_VALUE;
                    w_rd_resp = RESP_OKAY;
                end
                REG_CTRL_OFFS: begin
                    w_rd_resp = RESP_OKAY;
                end
                REG_SCRATCH_OFFS: begin
                    w_rd_data = r_scratch;
                    w_rd_resp = RESP_OKAY;
                end
                REG_DROP_OFFS: begin
                    w_rd_data = w_rd_drop;
                    w_rd_resp = RESP_OKAY;
                end
                default: begin
                    for (int i = 0; i < NUM_OUTPUTS; i++) begin
                        if (w_rd_addr == (REG_OUT_BASE + 32'(4*i))) begin
                            w_rd_data = w_rd_out[i];
                            w_rd_resp = RESP_OKAY;
                        end
                    end
                end
            endcase
        end
    end

    rd_state_t   r_rd_state;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;

    // Read channel FSM: sample register on AR handshake, hold R until taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b1;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            case (r_rd_state)
                RD_IDLE: begin
                    if (s_axil_arvalid && r_arready) begin
                        r_rdata    <= w_rd_data;
                        r_rresp    <= w_rd_resp;
                        r_arready  <= 1'b0;
                        r_rvalid   <= 1'b1;
                        r_rd_state <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_axil_rready) begin
                        r_rvalid   <= 1'b0;
                        r_arready  <= 1'b1;
                        r_rd_state <= RD_IDLE;
                    end
                end
                default: r_rd_state <= RD_IDLE;
            endcase
        end
    end

    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;

endmodule
`default_nettype wire
